// File: rtl/freq_addr_sched.sv
// freq_addr_sched
//   Round-robin scheduler in front of the 8-entry frequency register bank
//   address port. Two requesters each ask for a burst (start address plus
//   beat count minus one). One requester is granted at a time, and its
//   address sequence is issued on a valid/ready stream. Addresses wrap
//   modulo 2**ADDR_W.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req[1:0]            level requests, sampled only while idle
//   start_addr0/1       first address of each requester's burst
//   len0/1              beat count minus 1 of each requester's burst
//   flush               abort the current burst (no done pulse)
//   gnt[1:0]            one-hot grant, held for the whole burst
//   addr_valid/ready    address beat handshake
//   addr, addr_last     current address and final-beat flag
//   addr_src            index of the granted requester
//   busy                high while a burst is in progress
//   done[1:0]           one-cycle completion pulse per requester
//
// Handshake: a beat transfers on a rising edge where addr_valid and
// addr_ready are both high. While addr_valid is high and addr_ready is low,
// addr, addr_last, addr_src and gnt stay stable. addr_valid never drops
// before its beat transfers, except on flush or reset.
module freq_addr_sched #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] start_addr0,
  input  logic [ADDR_W-1:0] len0,
  input  logic [ADDR_W-1:0] start_addr1,
  input  logic [ADDR_W-1:0] len1,
  input  logic              flush,
  output logic [1:0]        gnt,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_last,
  output logic              addr_src,
  output logic              busy,
  output logic [1:0]        done
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;   // current beat address
  logic [ADDR_W-1:0] cnt_q;    // beats remaining after the current one
  logic              src_q;    // granted requester
  logic              ptr_q;    // requester favoured on a tie
  logic [1:0]        done_q;
  logic              win;
  logic              hs;
  logic              last_hs;

  // A tie goes to the pointer. Otherwise, the single active requester wins.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) win = ptr_q;
    else              win = req[1];
  end

  assign hs      = (state_q == BURST) && addr_ready;
  assign last_hs = hs && (cnt_q == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Flush takes priority over a last-beat handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req != 2'b00)     state_d = BURST;
      BURST:   if (flush || last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst datapath, round-robin pointer and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
      src_q  <= 1'b0;
      ptr_q  <= 1'b0;
      done_q <= 2'b00;
    end else begin
      done_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (req != 2'b00) begin
            addr_q <= win ? start_addr1 : start_addr0;
            cnt_q  <= win ? len1 : len0;
            src_q  <= win;
          end
        end
        BURST: begin
          if (flush) begin
            ptr_q <= ~src_q;
          end else if (hs) begin
            if (cnt_q == '0) begin
              ptr_q  <= ~src_q;
              done_q <= src_q ? 2'b10 : 2'b01;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
              cnt_q  <= cnt_q - ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs. While idle, every beat-related output is forced to zero.
  always_comb begin
    busy       = (state_q == BURST);
    addr_valid = busy;
    addr       = busy ? addr_q : '0;
    addr_last  = busy && (cnt_q == '0);
    addr_src   = busy ? src_q : 1'b0;
    gnt        = busy ? (src_q ? 2'b10 : 2'b01) : 2'b00;
    done       = done_q;
  end

endmodule

// File: tb/tb_freq_addr_sched.sv
module tb_freq_addr_sched;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [AW-1:0] start_addr0, len0, start_addr1, len1;
  logic          flush;
  logic [1:0]    gnt;
  logic          addr_valid;
  logic          addr_ready;
  logic [AW-1:0] addr;
  logic          addr_last;
  logic          addr_src;
  logic          busy;
  logic [1:0]    done;

  freq_addr_sched #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .start_addr0(start_addr0), .len0(len0),
    .start_addr1(start_addr1), .len1(len1),
    .flush(flush), .gnt(gnt), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .addr(addr), .addr_last(addr_last),
    .addr_src(addr_src), .busy(busy), .done(done)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard
  int            n_cmp = 0;
  int            n_err = 0;
  int            m_ptr = 0;   // model: requester favoured on a tie
  logic [AW-1:0] exp_q[$];    // expected address beats of the running burst

  function automatic logic [AW-1:0] rnd();
    return AW'($urandom_range(0, (1 << AW) - 1));
  endfunction

  // Issue one burst from an idle DUT, starting at the current negedge.
  // ready_mode: 0 = always ready, 1 = random, 2 = pattern 1,0,0,1.
  // flush_beat: beat index on which flush is raised (-1 = never).
  task automatic do_burst(input logic [1:0] r,
                          input logic [AW-1:0] a0, input logic [AW-1:0] l0,
                          input logic [AW-1:0] a1, input logic [AW-1:0] l1,
                          input int flush_beat, input int ready_mode);
    int            win;
    int            ln;
    int            beat;
    int            cyc;
    bit            flushed;
    logic [AW-1:0] sa;
    logic [1:0]    exp_gnt;
    logic [1:0]    exp_done;
    req = r; start_addr0 = a0; len0 = l0; start_addr1 = a1; len1 = l1;
    flush = 1'b0;
    win = (r == 2'b11) ? m_ptr : (r[1] ? 1 : 0);
    sa  = win ? a1 : a0;
    ln  = win ? int'(l1) : int'(l0);
    exp_q.delete();
    for (int i = 0; i <= ln; i++) exp_q.push_back(AW'((int'(sa) + i) % (1 << AW)));
    exp_gnt = (win == 1) ? 2'b10 : 2'b01;
    beat = 0; cyc = 0; flushed = 0;
    while (exp_q.size() > 0 && !flushed && cyc < 100) begin
      @(negedge clk);
      cyc++;
      n_cmp++;
      if (addr_valid !== 1'b1 || addr !== exp_q[0] || addr_last !== 1'(exp_q.size() == 1) ||
          gnt !== exp_gnt || addr_src !== 1'(win) || busy !== 1'b1 || done !== 2'b00) begin
        n_err++;
        $display("FAIL beat%0d cyc%0d: valid=%b addr=%0d last=%b gnt=%b src=%b busy=%b done=%b; required valid=1 addr=%0d last=%b gnt=%b src=%0d busy=1 done=00",
                 beat, cyc, addr_valid, addr, addr_last, gnt, addr_src, busy, done,
                 exp_q[0], exp_q.size() == 1, exp_gnt, win);
      end
      // Scramble the request inputs. The DUT must ignore them during the burst.
      req = 2'($urandom_range(0, 3));
      start_addr0 = rnd(); len0 = rnd(); start_addr1 = rnd(); len1 = rnd();
      case (ready_mode)
        0:       addr_ready = 1'b1;
        1:       addr_ready = 1'($urandom_range(0, 1));
        default: addr_ready = ((cyc % 4) == 1) || ((cyc % 4) == 0);
      endcase
      if (beat == flush_beat) begin
        flush = 1'b1;
        flushed = 1;
      end else if (addr_ready) begin
        void'(exp_q.pop_front());
        beat++;
      end
      if (exp_q.size() == 0 || flushed) req = 2'b00;
    end
    if (exp_q.size() > 0 && !flushed) begin
      n_cmp++; n_err++;
      $display("FAIL burst_timeout: %0d beats outstanding after %0d cycles, required 0", exp_q.size(), cyc);
    end
    m_ptr = 1 - win;
    exp_done = flushed ? 2'b00 : exp_gnt;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (addr_valid !== 1'b0 || busy !== 1'b0 || gnt !== 2'b00 || addr !== '0 ||
        addr_last !== 1'b0 || addr_src !== 1'b0 || done !== exp_done) begin
      n_err++;
      $display("FAIL burst_end: valid=%b busy=%b gnt=%b addr=%0d last=%b src=%b done=%b; required all 0, done=%b",
               addr_valid, busy, gnt, addr, addr_last, addr_src, done, exp_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; flush = 1'b0; addr_ready = 1'b1;
    start_addr0 = '0; len0 = '0; start_addr1 = '0; len1 = '0;
    #12;
    n_cmp++;
    if (gnt !== 2'b00 || addr_valid !== 1'b0 || addr !== '0 || addr_last !== 1'b0 ||
        addr_src !== 1'b0 || busy !== 1'b0 || done !== 2'b00) begin
      n_err++;
      $display("FAIL reset: gnt=%b valid=%b addr=%0d last=%b src=%b busy=%b done=%b; required all 0",
               gnt, addr_valid, addr, addr_last, addr_src, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_basic();
    do_burst(2'b01, 3'd5, 3'd2, rnd(), rnd(), -1, 0);   // 5,6,7
    do_burst(2'b10, rnd(), rnd(), 3'd6, 3'd3, -1, 0);   // 6,7,0,1
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_burst(2'b11, rnd(), rnd(), rnd(), rnd(), -1, 0);
  endtask

  task automatic test_stall();
    do_burst(2'b01, 3'd3, 3'd5, rnd(), rnd(), -1, 2);
    for (int i = 0; i < 8; i++)
      do_burst(2'($urandom_range(1, 3)), rnd(), rnd(), rnd(), rnd(), -1, 1);
  endtask

  task automatic test_flush();
    do_burst(2'b11, rnd(), 3'd7, rnd(), 3'd7, 2, 0);     // flush on beat 2
    do_burst(2'b11, rnd(), rnd(), rnd(), rnd(), -1, 0);  // other requester wins
    do_burst(2'b01, rnd(), 3'd3, rnd(), rnd(), 3, 0);    // flush with last handshake
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    req = 2'b01; flush = 1'b1; start_addr0 = 3'd2; len0 = 3'd0; addr_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (addr_valid !== 1'b1 || addr !== 3'd2 || addr_last !== 1'b1 || gnt !== 2'b01) begin
      n_err++;
      $display("FAIL flush_idle_grant: valid=%b addr=%0d last=%b gnt=%b; required 1 2 1 01",
               addr_valid, addr, addr_last, gnt);
    end
    flush = 1'b0; req = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (done !== 2'b01 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_done: done=%b busy=%b; required 01 0", done, busy);
    end
    m_ptr = 1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req = 2'b11; start_addr0 = 3'd1; len0 = 3'd7; start_addr1 = 3'd4; len1 = 3'd7;
    addr_ready = 1'b1;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_pre: busy=%b; required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 2'b00 || addr_valid !== 1'b0 || addr !== '0 || addr_last !== 1'b0 ||
        addr_src !== 1'b0 || busy !== 1'b0 || done !== 2'b00) begin
      n_err++;
      $display("FAIL async_reset: gnt=%b valid=%b addr=%0d last=%b src=%b busy=%b done=%b; required all 0",
               gnt, addr_valid, addr, addr_last, addr_src, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    do_burst(2'b11, rnd(), rnd(), rnd(), rnd(), -1, 0);  // requester 0 wins
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_flush();
    test_flush_idle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
